// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if : requester, memory and status bundle of the arbiter    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic              d_byte;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic              mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // master: the arbiter itself; slave: requesters plus the memory
  modport master (
    input  if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_req, mem_we, mem_byte, mem_addr, mem_wdata, busy
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : shares one fixed-latency memory port between fetch and   |
// | data requesters with alternating priority.                  Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_i;
  logic              w_grant_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_d;
  logic              r_mem_we;
  logic              r_mem_byte;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      IDLE: begin
        // on contention the side not served last wins
        if (bus.d_req && (!bus.if_req || !r_last_d)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = BUSY_D;
        end else if (bus.if_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I:  if (r_cnt == '0) w_state_nxt = RESP_I;
      BUSY_D:  if (r_cnt == '0) w_state_nxt = RESP_D;
      RESP_I:  w_state_nxt = IDLE;
      RESP_D:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_last_d    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_byte  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else if (w_grant_d) begin
      r_mem_addr  <= bus.d_addr;
      r_mem_we    <= bus.d_we;
      r_mem_byte  <= bus.d_byte;
      r_mem_wdata <= bus.d_wdata;
      r_cnt       <= CNT_LOAD;
      r_last_d    <= 1'b1;
    end else if (w_grant_i) begin
      r_mem_addr  <= bus.if_addr;
      r_mem_we    <= 1'b0;
      r_mem_byte  <= 1'b0;
      r_mem_wdata <= '0;
      r_cnt       <= CNT_LOAD;
      r_last_d    <= 1'b0;
    end else if (r_state == BUSY_I || r_state == BUSY_D) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == BUSY_I) begin
        r_if_rdata <= bus.mem_rdata;
      end else if (r_mem_we) begin
        r_d_rdata <= '0;
      end else if (r_mem_byte) begin
        r_d_rdata <= {{(DATA_W-8){bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      end else begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign bus.if_ready  = (r_state == RESP_I);
  assign bus.d_ready   = (r_state == RESP_D);
  assign bus.busy      = (r_state != IDLE);
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_byte  = r_mem_byte;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;
  localparam int L = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   busy_cnt;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0050_0093;
      32'h200: return 32'hCAFE_0001;
      32'h300: return 32'h0000_00F0;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  // memory model: read data is valid only in the last busy cycle
  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else       busy_cnt <= bus.mem_req ? busy_cnt + 1 : 0;
  end
  assign bus.mem_rdata = (bus.mem_req && busy_cnt == L - 1) ? memval(bus.mem_addr) : 32'hDEAD_BEEF;

  task automatic drive_idle();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.if_req  = 1'($urandom_range(0, 1));
      bus.d_req   = 1'($urandom_range(0, 1));
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_byte  = 1'($urandom_range(0, 1));
      bus.if_addr = $urandom;
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({bus.if_ready, bus.d_ready, bus.mem_req, bus.mem_we, bus.mem_byte, bus.busy} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctl: got %b want 000000",
                 {bus.if_ready, bus.d_ready, bus.mem_req, bus.mem_we, bus.mem_byte, bus.busy});
      end
      n_checks++;
      if ({bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 128'b0) begin
        n_fail++;
        $display("FAIL reset_data: got %h %h %h %h want all zero",
                 bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata);
      end
    end
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got req/busy %b want 00", {bus.mem_req, bus.busy});
    end
  endtask

  task automatic test_single_fetch();
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    for (int c = 0; c <= 5; c++) begin
      logic [3:0] exp_ctl;
      @(negedge clk);
      exp_ctl = {(c >= 1 && c <= 3), (c == 4), 1'b0, (c >= 1 && c <= 4)};
      n_checks++;
      if ({bus.mem_req, bus.if_ready, bus.d_ready, bus.busy} !== exp_ctl) begin
        n_fail++;
        $display("FAIL fetch_ctl c%0d: got %b want %b", c,
                 {bus.mem_req, bus.if_ready, bus.d_ready, bus.busy}, exp_ctl);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if ({bus.mem_addr, bus.mem_we} !== {32'h100, 1'b0}) begin
          n_fail++;
          $display("FAIL fetch_mem c%0d: got addr %h we %b want 100 0", c, bus.mem_addr, bus.mem_we);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (bus.if_rdata !== 32'h0050_0093) begin
          n_fail++;
          $display("FAIL fetch_rdata: got %h want 00500093", bus.if_rdata);
        end
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = 32'h200;
    for (int c = 0; c <= 20; c++) begin
      int         ph;
      logic       own_d;
      logic [3:0] exp_ctl;
      @(negedge clk);
      ph      = c % 5;
      own_d   = ((c / 5) % 2) == 0;
      exp_ctl = {(ph >= 1 && ph <= 3), (ph == 4 && !own_d), (ph == 4 && own_d), (ph != 0)};
      n_checks++;
      if ({bus.mem_req, bus.if_ready, bus.d_ready, bus.busy} !== exp_ctl) begin
        n_fail++;
        $display("FAIL contend_ctl c%0d: got %b want %b", c,
                 {bus.mem_req, bus.if_ready, bus.d_ready, bus.busy}, exp_ctl);
      end
      if (ph >= 1 && ph <= 3) begin
        n_checks++;
        if (bus.mem_addr !== (own_d ? 32'h200 : 32'h100)) begin
          n_fail++;
          $display("FAIL contend_addr c%0d: got %h want %h", c, bus.mem_addr,
                   own_d ? 32'h200 : 32'h100);
        end
      end
      if (ph == 4) begin
        n_checks++;
        if (own_d ? (bus.d_rdata !== 32'hCAFE_0001) : (bus.if_rdata !== 32'h0050_0093)) begin
          n_fail++;
          $display("FAIL contend_rdata c%0d: got i=%h d=%h", c, bus.if_rdata, bus.d_rdata);
        end
      end
      if (c == 19) drive_idle();
    end
  endtask

  task automatic test_byte();
    logic [31:0] tv_addr  [3];
    logic [31:0] tv_wdata [3];
    logic [31:0] tv_exp   [3];
    logic        tv_we    [3];
    logic        tv_byte  [3];
    tv_addr  = '{32'h300, 32'h400, 32'h300};
    tv_wdata = '{32'h0, 32'h1234_5678, 32'h0};
    tv_exp   = '{32'hFFFF_FFF0, 32'h0, 32'h0000_00F0};
    tv_we    = '{1'b0, 1'b1, 1'b0};
    tv_byte  = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      bus.d_req   = 1'b1;
      bus.d_we    = tv_we[t];
      bus.d_byte  = tv_byte[t];
      bus.d_addr  = tv_addr[t];
      bus.d_wdata = tv_wdata[t];
      for (int c = 0; c <= 4; c++) begin
        logic [3:0] exp_ctl;
        @(negedge clk);
        exp_ctl = {(c >= 1 && c <= 3), 1'b0, (c == 4), (c != 0)};
        n_checks++;
        if ({bus.mem_req, bus.if_ready, bus.d_ready, bus.busy} !== exp_ctl) begin
          n_fail++;
          $display("FAIL byte_ctl t%0d c%0d: got %b want %b", t, c,
                   {bus.mem_req, bus.if_ready, bus.d_ready, bus.busy}, exp_ctl);
        end
        if (c >= 1 && c <= 3) begin
          n_checks++;
          if ({bus.mem_we, bus.mem_byte, bus.mem_addr} !== {tv_we[t], tv_byte[t], tv_addr[t]}) begin
            n_fail++;
            $display("FAIL byte_mem t%0d c%0d: got we %b byte %b addr %h want %b %b %h", t, c,
                     bus.mem_we, bus.mem_byte, bus.mem_addr, tv_we[t], tv_byte[t], tv_addr[t]);
          end
          if (tv_we[t]) begin
            n_checks++;
            if (bus.mem_wdata !== tv_wdata[t]) begin
              n_fail++;
              $display("FAIL byte_wdata t%0d: got %h want %h", t, bus.mem_wdata, tv_wdata[t]);
            end
          end
        end
        if (c == 4) begin
          n_checks++;
          if (bus.d_rdata !== tv_exp[t]) begin
            n_fail++;
            $display("FAIL byte_rdata t%0d: got %h want %h", t, bus.d_rdata, tv_exp[t]);
          end
          bus.d_req = 1'b0;
        end
      end
    end
    n_checks++;
    if (bus.if_rdata !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL if_rdata_hold: got %h want 00500093", bus.if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_byte = 1'b0;
    bus.d_addr = 32'h200;
    for (int c = 0; c <= 2; c++) @(negedge clk);
    n_checks++;
    if ({bus.mem_req, bus.busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_busy: got req/busy %b want 11", {bus.mem_req, bus.busy});
    end
    reset = 1'b1;
    bus.d_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.busy, bus.d_ready, bus.d_rdata} !== 35'b0) begin
      n_fail++;
      $display("FAIL mid_async: got req %b busy %b rdy %b rdata %h want all zero",
               bus.mem_req, bus.busy, bus.d_ready, bus.d_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.d_ready, bus.busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_hold c%0d: got rdy/busy %b want 00", c, {bus.d_ready, bus.busy});
      end
    end
    @(posedge clk); #1;
    reset      = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h300;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_req, bus.d_ready} !== {(c >= 1 && c <= 3), (c == 4)}) begin
        n_fail++;
        $display("FAIL mid_after c%0d: got req/rdy %b want %b", c, {bus.mem_req, bus.d_ready},
                 {(c >= 1 && c <= 3), (c == 4)});
      end
      if (c == 4) begin
        n_checks++;
        if (bus.d_rdata !== 32'h0000_00F0) begin
          n_fail++;
          $display("FAIL mid_rdata: got %h want 000000f0", bus.d_rdata);
        end
        bus.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{32'h200, 32'h300, 32'h500};
    datas = '{32'hCAFE_0001, 32'h0000_00F0, 32'h0500_A5A5};
    @(posedge clk); #1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_byte = 1'b0;
    bus.d_addr = addrs[0];
    for (int c = 0; c <= 15; c++) begin
      int         ph;
      int         k;
      logic [2:0] exp_ctl;
      @(negedge clk);
      ph      = c % 5;
      k       = c / 5;
      exp_ctl = {(ph >= 1 && ph <= 3), (ph == 4), (ph != 0)};
      n_checks++;
      if ({bus.mem_req, bus.d_ready, bus.busy} !== exp_ctl) begin
        n_fail++;
        $display("FAIL b2b_ctl c%0d: got %b want %b", c, {bus.mem_req, bus.d_ready, bus.busy}, exp_ctl);
      end
      if (ph >= 1 && ph <= 3) begin
        n_checks++;
        if (bus.mem_addr !== addrs[k]) begin
          n_fail++;
          $display("FAIL b2b_addr c%0d: got %h want %h", c, bus.mem_addr, addrs[k]);
        end
      end
      if (ph == 4) begin
        n_checks++;
        if (bus.d_rdata !== datas[k]) begin
          n_fail++;
          $display("FAIL b2b_rdata c%0d: got %h want %h", c, bus.d_rdata, datas[k]);
        end
        if (k < 2) bus.d_addr = addrs[k+1];
        else       bus.d_req  = 1'b0;
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    n_checks = 0;
    n_fail   = 0;
    drive_idle();
    test_reset();
    test_single_fetch();
    test_contention();
    test_byte();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
